// File: rtl/mem_dump_tx.sv
// rtl/mem_dump_tx.sv - reads a data-memory address range and streams each 16-bit word out over UART TX
module mem_dump_tx #(
    parameter int ARQ          = 16,
    parameter int MEM_ADDR     = 10,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MEM_ADDR-1:0] base_addr,
    input  logic [MEM_ADDR:0]   word_count,
    output logic                mem_rd_en,
    output logic [MEM_ADDR-1:0] mem_addr,
    input  logic [ARQ-1:0]      mem_rd_data,
    output logic                tx,
    output logic                busy,
    output logic                done,
    output logic [MEM_ADDR:0]   words_sent
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [MEM_ADDR:0] ONE_WORD = (MEM_ADDR+1)'(1);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_CAP, TX_START, TX_DATA, TX_STOP, NEXT, FIN
    } state_t;

    state_t state, state_nx;

    logic [MEM_ADDR-1:0] addr;
    logic [MEM_ADDR:0]   remaining;
    logic [7:0]          lo_byte;
    logic [7:0]          shift;
    logic                byte_sel;
    logic [CW-1:0]       baud_cnt;
    logic [2:0]          bit_cnt;
    logic                baud_done;
    logic                in_tx;

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign in_tx     = (state == TX_START) || (state == TX_DATA) || (state == TX_STOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // An empty request passes through NEXT without counting so that busy
    // is seen for one cycle and done lands in the cycle after it.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = (word_count == '0) ? NEXT : RD_REQ;
            RD_REQ:   state_nx = RD_CAP;
            RD_CAP:   state_nx = TX_START;
            TX_START: if (baud_done) state_nx = TX_DATA;
            TX_DATA:  if (baud_done && bit_cnt == 3'd7) state_nx = TX_STOP;
            TX_STOP:  if (baud_done) state_nx = byte_sel ? NEXT : TX_START;
            NEXT:     state_nx = (remaining <= ONE_WORD) ? FIN : RD_REQ;
            FIN:      state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            remaining  <= '0;
            lo_byte    <= '0;
            shift      <= '0;
            byte_sel   <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            words_sent <= '0;
        end else begin
            baud_cnt <= (in_tx && !baud_done) ? baud_cnt + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr       <= base_addr;
                        remaining  <= word_count;
                        words_sent <= '0;
                    end
                end
                RD_CAP: begin
                    shift    <= mem_rd_data[15:8];
                    lo_byte  <= mem_rd_data[7:0];
                    byte_sel <= 1'b0;
                    bit_cnt  <= '0;
                end
                TX_DATA: begin
                    if (baud_done) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                TX_STOP: begin
                    if (baud_done && !byte_sel) begin
                        shift    <= lo_byte;
                        byte_sel <= 1'b1;
                        bit_cnt  <= '0;
                    end
                end
                NEXT: begin
                    if (remaining != '0) begin
                        words_sent <= words_sent + 1'b1;
                        remaining  <= remaining - 1'b1;
                        addr       <= addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        tx        = 1'b1;
        done      = 1'b0;
        busy      = (state != IDLE) && (state != FIN);
        case (state)
            RD_REQ: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr;
            end
            TX_START: tx = 1'b0;
            TX_DATA:  tx = shift[0];
            FIN:      done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb/tb_mem_dump_tx.sv - randomized self-checking bench for mem_dump_tx against a cycle-level waveform model
module tb_mem_dump_tx;

    localparam int C  = 4;
    localparam int AW = 10;
    localparam int FR = 20 * C + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rd_data;
    logic          tx, busy, done;
    logic [AW:0]   words_sent;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:1023];

    bit tx_q[$];
    bit exp_tx[$];
    int rd_cyc_q[$], rd_addr_q[$], exp_rd_cyc[$], exp_rd_addr[$];
    int busy_n, done_cyc, done_n, ws_at_done;
    int exp_done, exp_busy, first_bad;

    mem_dump_tx #(.ARQ(16), .MEM_ADDR(AW), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .tx(tx), .busy(busy), .done(done),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    task automatic kick(input int b, input int n);
        @(negedge clk);
        base_addr  = AW'(b);
        word_count = (AW+1)'(n);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records one cycle per entry starting at the cycle after start was sampled.
    task automatic capture(input int limit, input int restart_cyc);
        tx_q.delete(); rd_cyc_q.delete(); rd_addr_q.delete();
        busy_n = 0; done_cyc = -1; done_n = 0; ws_at_done = -1;
        for (int k = 1; k <= limit; k++) begin
            tx_q.push_back(tx);
            if (mem_rd_en) begin
                rd_cyc_q.push_back(k);
                rd_addr_q.push_back(int'(mem_addr));
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc   = k;
                    ws_at_done = int'(words_sent);
                end
            end
            if (done_cyc >= 0 && k == done_cyc + 2) break;
            if (k == restart_cyc) begin
                start = 1'b1; base_addr = 7; word_count = 5;
            end else if (k == restart_cyc + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic build_exp(input int b, input int n);
        logic [15:0] wd;
        logic [7:0]  byt;
        int a;
        exp_tx.delete(); exp_rd_cyc.delete(); exp_rd_addr.delete();
        for (int w = 0; w < n; w++) begin
            a  = (b + w) % 1024;
            wd = mem[a];
            exp_rd_cyc.push_back(1 + w * FR);
            exp_rd_addr.push_back(a);
            exp_tx.push_back(1'b1);
            exp_tx.push_back(1'b1);
            for (int h = 0; h < 2; h++) begin
                byt = (h == 0) ? wd[15:8] : wd[7:0];
                repeat (C) exp_tx.push_back(1'b0);
                for (int i = 0; i < 8; i++) repeat (C) exp_tx.push_back(byt[i]);
                repeat (C) exp_tx.push_back(1'b1);
            end
            exp_tx.push_back(1'b1);
        end
        exp_done = (n == 0) ? 2 : n * FR + 1;
        exp_busy = (n == 0) ? 1 : n * FR;
        while (exp_tx.size() < exp_done + 2) exp_tx.push_back(1'b1);
    endtask

    function automatic int tx_diff();
        int nbad = 0;
        first_bad = -1;
        for (int i = 0; i < exp_tx.size(); i++) begin
            if (i >= tx_q.size() || tx_q[i] !== exp_tx[i]) begin
                nbad++;
                if (first_bad < 0) first_bad = i + 1;
            end
        end
        return nbad;
    endfunction

    function automatic int rd_diff();
        int nbad = (rd_cyc_q.size() > exp_rd_cyc.size()) ? rd_cyc_q.size() - exp_rd_cyc.size()
                                                         : exp_rd_cyc.size() - rd_cyc_q.size();
        for (int i = 0; i < exp_rd_cyc.size() && i < rd_cyc_q.size(); i++)
            if (rd_cyc_q[i] != exp_rd_cyc[i] || rd_addr_q[i] != exp_rd_addr[i]) nbad++;
        return nbad;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
        checks++; if (mem_rd_en !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL reset_mem got en=%b addr=%0h exp 0/0", mem_rd_en, mem_addr); end
        checks++; if (words_sent !== '0) begin errors++; $display("FAIL reset_words_sent got %0d exp 0", words_sent); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        mem[5] = 16'hA55A;
        kick(5, 1); capture(FR + 20, -1); build_exp(5, 1);
        checks++; if (done_cyc !== 84) begin errors++; $display("FAIL single_done_cycle got %0d exp 84", done_cyc); end
        checks++; if (tx_diff() != 0) begin errors++; $display("FAIL single_tx_wave got mismatch at cycle %0d exp none", first_bad); end
        checks++; if (rd_diff() != 0) begin errors++; $display("FAIL single_reads got %0d reads first_addr %0h exp 1 read at 5", rd_addr_q.size(), rd_addr_q.size() ? rd_addr_q[0] : -1); end
        checks++; if (ws_at_done !== 1) begin errors++; $display("FAIL single_words_sent got %0d exp 1", ws_at_done); end
        checks++; if (busy_n !== exp_busy || done_n !== 1) begin errors++; $display("FAIL single_busy_done got busy=%0d done=%0d exp %0d/1", busy_n, done_n, exp_busy); end
    endtask

    task automatic test_zero();
        kick(9, 0); capture(20, -1); build_exp(9, 0);
        checks++; if (done_cyc !== exp_done) begin errors++; $display("FAIL zero_done_cycle got %0d exp %0d", done_cyc, exp_done); end
        checks++; if (busy_n !== 1 || done_n !== 1) begin errors++; $display("FAIL zero_busy_done got busy=%0d done=%0d exp 1/1", busy_n, done_n); end
        checks++; if (rd_cyc_q.size() != 0 || tx_diff() != 0) begin errors++; $display("FAIL zero_quiet got reads=%0d txbad=%0d exp 0/0", rd_cyc_q.size(), first_bad); end
        checks++; if (ws_at_done !== 0) begin errors++; $display("FAIL zero_words_sent got %0d exp 0", ws_at_done); end
    endtask

    task automatic test_wrap();
        mem[1023] = 16'h1234; mem[0] = 16'hBEEF;
        kick(1023, 2); capture(2 * FR + 20, -1); build_exp(1023, 2);
        checks++; if (rd_diff() != 0) begin errors++; $display("FAIL wrap_reads got n=%0d addr0=%0h exp 3ff,0", rd_addr_q.size(), rd_addr_q.size() ? rd_addr_q[0] : -1); end
        checks++; if (tx_diff() != 0) begin errors++; $display("FAIL wrap_tx_wave got mismatch at cycle %0d exp none", first_bad); end
        checks++; if (done_cyc !== exp_done || ws_at_done !== 2) begin errors++; $display("FAIL wrap_done got cyc=%0d ws=%0d exp %0d/2", done_cyc, ws_at_done, exp_done); end
    endtask

    task automatic test_restart();
        mem[20] = 16'hC3E1;
        kick(20, 1); capture(FR + 20, 10); build_exp(20, 1);
        checks++; if (rd_diff() != 0) begin errors++; $display("FAIL restart_reads got n=%0d exp 1 at 14", rd_addr_q.size()); end
        checks++; if (tx_diff() != 0) begin errors++; $display("FAIL restart_tx_wave got mismatch at cycle %0d exp none", first_bad); end
        checks++; if (done_cyc !== exp_done || ws_at_done !== 1) begin errors++; $display("FAIL restart_done got cyc=%0d ws=%0d exp %0d/1", done_cyc, ws_at_done, exp_done); end
    endtask

    task automatic test_multi();
        kick(100, 3); capture(3 * FR + 20, -1); build_exp(100, 3);
        checks++; if (rd_diff() != 0) begin errors++; $display("FAIL multi_reads got n=%0d exp 3", rd_addr_q.size()); end
        checks++; if (tx_diff() != 0) begin errors++; $display("FAIL multi_tx_wave got mismatch at cycle %0d exp none", first_bad); end
        checks++; if (done_cyc !== 3 * FR + 1) begin errors++; $display("FAIL multi_done_cycle got %0d exp %0d", done_cyc, 3 * FR + 1); end
        checks++; if (busy_n !== exp_busy || ws_at_done !== 3) begin errors++; $display("FAIL multi_busy_ws got busy=%0d ws=%0d exp %0d/3", busy_n, ws_at_done, exp_busy); end
    endtask

    task automatic test_reset_mid();
        int seen_done = 0;
        int seen_rd = 0;
        kick(40, 2);
        repeat (94) @(negedge clk);
        checks++; if (words_sent !== 1) begin errors++; $display("FAIL mid_pre_words_sent got %0d exp 1", words_sent); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_tx_busy got %b%b exp 10", tx, busy); end
        checks++; if (mem_rd_en !== 1'b0 || words_sent !== '0) begin errors++; $display("FAIL mid_rst_en_ws got %b/%0d exp 0/0", mem_rd_en, words_sent); end
        rst = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (done) seen_done++;
            if (mem_rd_en) seen_rd++;
        end
        checks++; if (seen_done != 0 || seen_rd != 0) begin errors++; $display("FAIL mid_quiet got done=%0d rd=%0d exp 0/0", seen_done, seen_rd); end
    endtask

    task automatic test_random();
        int b, n;
        for (int it = 0; it < 4; it++) begin
            b = $urandom_range(0, 1023);
            n = $urandom_range(1, 3);
            kick(b, n); capture(n * FR + 20, -1); build_exp(b, n);
            checks++; if (rd_diff() != 0) begin errors++; $display("FAIL rand%0d_reads got n=%0d exp %0d from %0h", it, rd_addr_q.size(), n, b); end
            checks++; if (tx_diff() != 0) begin errors++; $display("FAIL rand%0d_tx_wave got mismatch at cycle %0d exp none", it, first_bad); end
            checks++; if (done_cyc !== exp_done || ws_at_done !== n) begin errors++; $display("FAIL rand%0d_done got cyc=%0d ws=%0d exp %0d/%0d", it, done_cyc, ws_at_done, exp_done, n); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        test_reset();
        test_single();
        test_zero();
        test_wrap();
        test_restart();
        test_multi();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
